// File: rtl/scroll_sched_pkg.sv
// Shared types and parameter derivations for the scroll scheduler.
// Optional feature macro used by the design: SCROLL_SCHED_PREEMPT_EN.
package scroll_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic int calc_data_w(input int digits);
        return 7 * digits;
    endfunction

    // The display hold time never collapses to zero cycles.
    function automatic int calc_hold_cycles(input int freq, input int hold_ms);
        int c;
        c = freq / 1000 * hold_ms;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int calc_owner_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scroll_scheduler_if.sv
// Source-side request bundle and scroll-datapath outputs of the scroll scheduler.
// Handshake: i_req[k] is a level held with i_data/i_mode/i_scroll slice k stable until o_ack[k] pulses.
interface scroll_scheduler_if #(
    parameter int REQUESTERS = 3,
    parameter int DATA_W     = 28,
    parameter int OWNER_W    = 2
);
    logic [REQUESTERS-1:0]        i_req;
    logic [REQUESTERS*DATA_W-1:0] i_data;
    logic [REQUESTERS-1:0]        i_mode;
    logic [REQUESTERS-1:0]        i_scroll;
    logic [REQUESTERS-1:0]        o_ack;
    logic [DATA_W-1:0]            o_full;
    logic                         o_shift;
    logic                         o_enable;
    logic                         o_mode;
    logic [OWNER_W-1:0]           o_owner;
    logic                         o_busy;
    scroll_sched_pkg::state_t     o_dbg_state;

    modport master (
        output i_req, i_data, i_mode, i_scroll,
        input  o_ack, o_full, o_shift, o_enable, o_mode, o_owner, o_busy, o_dbg_state
    );

    modport slave (
        input  i_req, i_data, i_mode, i_scroll,
        output o_ack, o_full, o_shift, o_enable, o_mode, o_owner, o_busy, o_dbg_state
    );
endinterface

// File: rtl/scroll_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting source after i_last, wrapping.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);
    always_comb begin
        int k;
        k       = 0;
        o_valid = 1'b0;
        o_idx   = '0;
        // Scan farthest-first so the nearest requester after i_last overwrites the rest.
        for (int i = N; i >= 1; i--) begin
            k = int'(i_last) + i;
            if (k >= N) k = k - N;
            if (i_req[IDX_W'(k)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/scroll_scheduler.sv
// Shares one scroll display between several sources: arbitrate, load, shift once, hold.
// Define SCROLL_SCHED_PREEMPT_EN to let source 0 cut another source's hold short.
module scroll_scheduler
    import scroll_sched_pkg::*;
#(
    parameter int REQUESTERS = 3,
    parameter int DIGITS     = 4,
    parameter int FREQ       = 27_000_000,
    parameter int HOLD_MS    = 2000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    scroll_scheduler_if.slave bus
);
    localparam int DATA_W      = calc_data_w(DIGITS);
    localparam int HOLD_CYCLES = calc_hold_cycles(FREQ, HOLD_MS);
    localparam int OWNER_W     = calc_owner_w(REQUESTERS);
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(REQUESTERS - 1);

    state_t                r_state;
    logic [OWNER_W-1:0]    r_winner;
    logic [OWNER_W-1:0]    r_owner;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_full;
    logic                  r_mode;
    logic                  r_enable;
    logic                  r_shift;
    logic                  r_busy;
    logic [REQUESTERS-1:0] r_ack;

    logic               w_grant_valid;
    logic [OWNER_W-1:0] w_grant_idx;
    logic               w_sel_valid;
    logic [OWNER_W-1:0] w_sel_idx;

    rr_arbiter #(.N(REQUESTERS), .IDX_W(OWNER_W)) u_arb (
        .i_req   (bus.i_req),
        .i_last  (r_owner),
        .o_valid (w_grant_valid),
        .o_idx   (w_grant_idx)
    );

`ifdef SCROLL_SCHED_PREEMPT_EN
    logic r_preempt;

    // After a preemption source 0 wins regardless of the round-robin pointer.
    always_comb begin
        w_sel_valid = w_grant_valid;
        w_sel_idx   = w_grant_idx;
        if (r_preempt && bus.i_req[0]) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = '0;
        end
    end
`else
    assign w_sel_valid = w_grant_valid;
    assign w_sel_idx   = w_grant_idx;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_winner  <= OWNER_RST;
            r_owner   <= OWNER_RST;
            r_cnt     <= '0;
            r_full    <= '0;
            r_mode    <= 1'b0;
            r_enable  <= 1'b0;
            r_shift   <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= '0;
`ifdef SCROLL_SCHED_PREEMPT_EN
            r_preempt <= 1'b0;
`endif
        end else begin
            r_ack   <= '0;
            r_shift <= 1'b0;
            r_busy  <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
`ifdef SCROLL_SCHED_PREEMPT_EN
                    r_preempt <= 1'b0;
`endif
                    if (w_sel_valid) begin
                        r_winner <= w_sel_idx;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A request withdrawn before its ack is dropped without touching the display.
                    if (bus.i_req[r_winner]) begin
                        r_full   <= bus.i_data[r_winner*DATA_W +: DATA_W];
                        r_mode   <= bus.i_mode[r_winner];
                        r_enable <= bus.i_scroll[r_winner];
                        r_owner  <= r_winner;
                        r_ack    <= REQUESTERS'(1) << r_winner;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
`ifdef SCROLL_SCHED_PREEMPT_EN
                    if (bus.i_req[0] && (r_owner != '0)) begin
                        r_preempt <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else
`endif
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ack       = r_ack;
    assign bus.o_full      = r_full;
    assign bus.o_shift     = r_shift;
    assign bus.o_enable    = r_enable;
    assign bus.o_mode      = r_mode;
    assign bus.o_owner     = r_owner;
    assign bus.o_busy      = r_busy;
    assign bus.o_dbg_state = r_state;
endmodule

// File: tb/tb_scroll_scheduler.sv
// Self-checking bench for scroll_scheduler: directed scenarios plus a randomized run
// against a transaction-level model (arbitration slots, round-robin order, display contents).
module tb_scroll_scheduler;
    import scroll_sched_pkg::*;

    localparam int R       = 3;
    localparam int DIGITS  = 4;
    localparam int FREQ    = 1000;
    localparam int HOLD_MS = 4;
    localparam int DW      = calc_data_w(DIGITS);
    localparam int OW      = calc_owner_w(R);
    localparam int HOLD    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [R-1:0]    req_v    = '0;
    logic [R-1:0]    mode_v   = '0;
    logic [R-1:0]    scroll_v = '0;
    logic [DW-1:0]   src_data [R];
    logic [R*DW-1:0] data_bus;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic [DW-1:0] exp_q[$];

    scroll_scheduler_if #(.REQUESTERS(R), .DATA_W(DW), .OWNER_W(OW)) bus ();

    scroll_scheduler #(
        .REQUESTERS (R),
        .DIGITS     (DIGITS),
        .FREQ       (FREQ),
        .HOLD_MS    (HOLD_MS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always_comb begin
        data_bus = '0;
        for (int k = 0; k < R; k++) data_bus[k*DW +: DW] = src_data[k];
    end

    assign bus.i_req    = req_v;
    assign bus.i_data   = data_bus;
    assign bus.i_mode   = mode_v;
    assign bus.i_scroll = scroll_v;

    // Round-robin reference: first requesting source after the last owner.
    function automatic int rr_pick(input logic [R-1:0] v, input int last);
        for (int i = 1; i <= R; i++) begin
            if (v[(last + i) % R]) return (last + i) % R;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_v = '0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_v = 3'b111;
        @(posedge clk);
        #1;
        checks++; if (bus.o_full !== '0) begin errors++; $display("FAIL reset_full got %h want 0", bus.o_full); end
        checks++; if (bus.o_shift !== 1'b0) begin errors++; $display("FAIL reset_shift got %b want 0", bus.o_shift); end
        checks++; if (bus.o_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", bus.o_enable); end
        checks++; if (bus.o_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b want 0", bus.o_mode); end
        checks++; if (bus.o_ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b want 000", bus.o_ack); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_owner !== OW'(R-1)) begin errors++; $display("FAIL reset_owner got %0d want %0d", bus.o_owner, R-1); end
        checks++; if (bus.o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", bus.o_dbg_state); end
        req_v = '0;
    endtask

    task automatic test_single;
        logic [R-1:0] exp_ack;
        do_reset();
        src_data[0] = 28'h0001234;
        mode_v      = 3'b001;
        scroll_v    = 3'b001;
        req_v       = 3'b001;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_ack = (e == 2) ? 3'b001 : 3'b000;
            checks++; if (bus.o_ack !== exp_ack) begin errors++; $display("FAIL single_ack edge %0d got %b want %b", e, bus.o_ack, exp_ack); end
            checks++; if (bus.o_shift !== (e == 3)) begin errors++; $display("FAIL single_shift edge %0d got %b want %b", e, bus.o_shift, (e == 3)); end
            checks++; if (bus.o_busy !== (e >= 2 && e <= 7)) begin errors++; $display("FAIL single_busy edge %0d got %b want %b", e, bus.o_busy, (e >= 2 && e <= 7)); end
            if (e == 2) begin
                checks++; if (bus.o_full !== 28'h0001234) begin errors++; $display("FAIL single_full got %h want 0001234", bus.o_full); end
                checks++; if (bus.o_owner !== OW'(0)) begin errors++; $display("FAIL single_owner got %0d want 0", bus.o_owner); end
                checks++; if (bus.o_mode !== 1'b1 || bus.o_enable !== 1'b1) begin errors++; $display("FAIL single_mode_en got %b%b want 11", bus.o_mode, bus.o_enable); end
                req_v = '0;
            end
        end
    endtask

    task automatic test_round_robin;
        int order [4] = '{0, 1, 2, 0};
        int n      = 0;
        int last_e = 0;
        int got;
        do_reset();
        for (int k = 0; k < R; k++) src_data[k] = DW'(28'hA00000 + k);
        mode_v   = '0;
        scroll_v = 3'b111;
        req_v    = 3'b111;
        for (int e = 1; e <= 60 && n < 4; e++) begin
            tick();
            if (bus.o_ack != '0) begin
                got = -1;
                for (int k = 0; k < R; k++) if (bus.o_ack == (3'b001 << k)) got = k;
                checks++; if (got != order[n]) begin errors++; $display("FAIL rr_order grant %0d got %0d want %0d", n, got, order[n]); end
                checks++; if (bus.o_owner !== OW'(order[n])) begin errors++; $display("FAIL rr_owner grant %0d got %0d want %0d", n, bus.o_owner, order[n]); end
                checks++; if (bus.o_full !== src_data[order[n]]) begin errors++; $display("FAIL rr_full grant %0d got %h want %h", n, bus.o_full, src_data[order[n]]); end
                if (n > 0) begin
                    checks++; if (e - last_e != 3 + HOLD) begin errors++; $display("FAIL rr_spacing grant %0d got %0d want %0d", n, e - last_e, 3 + HOLD); end
                end
                last_e = e;
                n++;
                req_v = req_v & ~bus.o_ack;
            end else begin
                req_v = 3'b111;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rr_timeout got %0d grants want 4", n); end
        req_v = '0;
    endtask

    task automatic test_drop;
        do_reset();
        src_data[0] = 28'h0BEEF00;
        src_data[1] = 28'h5555555;
        mode_v      = '0;
        scroll_v    = 3'b001;
        req_v       = 3'b001;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 2) begin
                checks++; if (bus.o_ack !== 3'b001) begin errors++; $display("FAIL drop_first_ack got %b want 001", bus.o_ack); end
                req_v = '0;
            end
        end
        req_v = 3'b010;
        tick();
        req_v = '0;
        for (int e = 0; e < 20; e++) begin
            tick();
            checks++; if (bus.o_ack !== 3'b000) begin errors++; $display("FAIL drop_hold_ack edge %0d got %b want 000", e, bus.o_ack); end
            checks++; if (bus.o_full !== 28'h0BEEF00) begin errors++; $display("FAIL drop_hold_full edge %0d got %h want 0beef00", e, bus.o_full); end
        end
        req_v = 3'b010;
        tick();
        req_v = '0;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++; if (bus.o_ack !== 3'b000) begin errors++; $display("FAIL drop_idle_ack edge %0d got %b want 000", e, bus.o_ack); end
            checks++; if (bus.o_owner !== OW'(0) || bus.o_full !== 28'h0BEEF00) begin errors++; $display("FAIL drop_idle_display edge %0d got %0d/%h want 0/0beef00", e, bus.o_owner, bus.o_full); end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        src_data[2] = 28'h7654321;
        mode_v      = 3'b100;
        scroll_v    = 3'b100;
        req_v       = 3'b100;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 2) begin
                checks++; if (bus.o_ack !== 3'b100) begin errors++; $display("FAIL rstmid_ack got %b want 100", bus.o_ack); end
                req_v = '0;
            end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_full !== '0 || bus.o_mode !== 1'b0 || bus.o_enable !== 1'b0) begin errors++; $display("FAIL rstmid_clear got %h/%b/%b want 0/0/0", bus.o_full, bus.o_mode, bus.o_enable); end
        checks++; if (bus.o_busy !== 1'b0 || bus.o_shift !== 1'b0 || bus.o_ack !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl got busy %b shift %b ack %b want 0 0 000", bus.o_busy, bus.o_shift, bus.o_ack); end
        checks++; if (bus.o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state got %0d want IDLE", bus.o_dbg_state); end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++; if (bus.o_ack !== 3'b000 || bus.o_shift !== 1'b0) begin errors++; $display("FAIL rstmid_quiet edge %0d got ack %b shift %b want 000 0", e, bus.o_ack, bus.o_shift); end
        end
        src_data[0] = 28'h0000ACE;
        req_v       = 3'b001;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++; if (bus.o_ack !== ((e == 2) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL rstmid_resume edge %0d got %b", e, bus.o_ack); end
            if (e == 2) req_v = '0;
        end
    endtask

    task automatic test_hold_priority;
        int ack_e = -1;
        int exp_e;
        do_reset();
        src_data[0] = 28'h0000111;
        src_data[2] = 28'h0000222;
        req_v       = 3'b100;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e == 2) req_v = '0;
        end
        req_v = 3'b101;
        for (int e = 4; e <= 20 && ack_e < 0; e++) begin
            tick();
            if (bus.o_ack != '0) begin
                ack_e = e;
                checks++; if (bus.o_ack !== 3'b001) begin errors++; $display("FAIL prio_ack got %b want 001", bus.o_ack); end
            end
        end
`ifdef SCROLL_SCHED_PREEMPT_EN
        exp_e = 6;
`else
        exp_e = 9;
`endif
        checks++; if (ack_e != exp_e) begin errors++; $display("FAIL prio_ack_edge got %0d want %0d", ack_e, exp_e); end
        req_v = '0;
    endtask

    task automatic test_random;
        int next_arb, arb_e, pend_w, last, disp_owner;
        bit pend, disp_mode, disp_en, drain, done;
        bit exp_shift, exp_busy;
        logic [DW-1:0] disp_full, want_d;
        logic [R-1:0] req_now, exp_ack;
        do_reset();
        exp_q.delete();
        next_arb = 1; arb_e = -100; pend = 0; last = R - 1; disp_owner = R - 1;
        disp_full = '0; disp_mode = 0; disp_en = 0; done = 0;
        for (int e = 1; e <= 420; e++) begin
            drain = (e > 300);
            if (drain && !pend && req_v == '0 && e >= next_arb) begin
                done = 1;
                break;
            end
            req_now = req_v;
            tick();
            exp_ack   = '0;
            exp_shift = 0;
            if (pend && e == arb_e + 1) begin
                exp_ack    = R'(1) << pend_w;
                disp_full  = src_data[pend_w];
                disp_mode  = mode_v[pend_w];
                disp_en    = scroll_v[pend_w];
                disp_owner = pend_w;
                last       = pend_w;
            end
            if (pend && e == arb_e + 2) begin
                exp_shift = 1;
                pend      = 0;
            end
            exp_busy = (e >= arb_e + 1) && (e <= arb_e + 2 + HOLD);
            if (e >= next_arb && req_now != '0) begin
                pend_w   = rr_pick(req_now, last);
                arb_e    = e;
                next_arb = e + 3 + HOLD;
                pend     = 1;
                exp_q.push_back(src_data[pend_w]);
            end
            checks++; if (bus.o_ack !== exp_ack) begin errors++; $display("FAIL rand_ack edge %0d got %b want %b", e, bus.o_ack, exp_ack); end
            checks++; if (bus.o_shift !== exp_shift) begin errors++; $display("FAIL rand_shift edge %0d got %b want %b", e, bus.o_shift, exp_shift); end
            checks++; if (bus.o_busy !== exp_busy) begin errors++; $display("FAIL rand_busy edge %0d got %b want %b", e, bus.o_busy, exp_busy); end
            checks++; if (bus.o_full !== disp_full || bus.o_mode !== disp_mode || bus.o_enable !== disp_en) begin
                errors++; $display("FAIL rand_display edge %0d got %h/%b/%b want %h/%b/%b", e, bus.o_full, bus.o_mode, bus.o_enable, disp_full, disp_mode, disp_en);
            end
            checks++; if (bus.o_owner !== OW'(disp_owner)) begin errors++; $display("FAIL rand_owner edge %0d got %0d want %0d", e, bus.o_owner, disp_owner); end
            if (bus.o_ack != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_sb edge %0d got unexpected ack %b want none", e, bus.o_ack);
                end else begin
                    want_d = exp_q.pop_front();
                    if (bus.o_full !== want_d) begin errors++; $display("FAIL rand_sb_data edge %0d got %h want %h", e, bus.o_full, want_d); end
                end
            end
            for (int k = 0; k < R; k++) begin
                if (exp_ack[k]) begin
                    req_v[k] = 1'b0;
                end else if (!drain && !req_v[k] && $urandom_range(0, 3) == 0
`ifdef SCROLL_SCHED_PREEMPT_EN
                             && k != 0
`endif
                            ) begin
                    src_data[k] = DW'($urandom);
                    mode_v[k]   = 1'($urandom_range(0, 1));
                    scroll_v[k] = 1'($urandom_range(0, 1));
                    req_v[k]    = 1'b1;
                end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL rand_drain_timeout got pending req %b want drained", req_v); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_sb_leftover got %0d entries want 0", exp_q.size()); end
        req_v = '0;
    endtask

    initial begin
        for (int k = 0; k < R; k++) src_data[k] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_hold_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/scroll_scheduler.md
SCROLL_SCHEDULER -- requirements
Module: scroll_scheduler

Interface
REQ-001 SHALL have parameter REQUESTERS, default 3: number of message sources sharing one scroll display.
REQ-002 SHALL have parameter DIGITS, default 4: message length in digits; DATA_W = 7*DIGITS.
REQ-003 SHALL have parameters FREQ, default 27_000_000, and HOLD_MS, default 2000; HOLD_CYCLES = FREQ/1000*HOLD_MS, minimum 1.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_req, input, REQUESTERS: level request per source, held until acked.
REQ-007 SHALL have port i_data, input, REQUESTERS*DATA_W: message per source, slice k = bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port i_mode, input, REQUESTERS: per-source mode, 0 hex, 1 custom.
REQ-009 SHALL have port i_scroll, input, REQUESTERS: per-source scroll-enable request.
REQ-010 SHALL have port o_ack, output, REQUESTERS: one-cycle one-hot pulse when a source's message is captured.
REQ-011 SHALL have ports o_full (DATA_W), o_shift (1), o_enable (1), o_mode (1), all outputs: drive the downstream scroll datapath.
REQ-012 SHALL have port o_owner, output, $clog2(REQUESTERS) (min 1): index of the source on display; port o_busy, output, 1: high outside IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> SHIFT -> HOLD -> IDLE.
REQ-014 In IDLE, any i_req bit high SHALL select a winner by round-robin starting at (last owner + 1) mod REQUESTERS, then enter LOAD on the next edge.
REQ-015 In LOAD, the FSM SHALL register o_full, o_mode, o_enable and o_owner from the winner's slice and pulse o_ack[winner] for exactly this cycle.
REQ-016 In SHIFT, o_shift SHALL be high for exactly one cycle; o_shift SHALL be low in every other state.
REQ-017 o_full, o_mode and o_enable SHALL be stable from LOAD until the next LOAD.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles, counted by a hold counter cleared on HOLD entry, then return to IDLE.
REQ-019 On return to IDLE with no request pending, the last message SHALL stay displayed with o_enable unchanged, and o_shift SHALL not pulse.
REQ-020 A request that deasserts before its ack SHALL be dropped without side effects; i_req changes during LOAD/SHIFT/HOLD SHALL not alter the current owner.
REQ-021 With REQUESTERS=1, the sole source SHALL win every arbitration.
REQ-022 Latency from i_req rising in IDLE to o_ack SHALL be 2 cycles, and to o_shift 3 cycles.

Reset
REQ-023 While i_rst_n=0: state IDLE, o_full=0, o_shift=0, o_enable=0, o_mode=0, o_ack=0, o_busy=0, o_owner=REQUESTERS-1 (first grant is source 0), hold counter 0.
REQ-024 Reset asserted mid-operation SHALL abort immediately with no further ack or shift pulse; operation resumes from IDLE on the first edge after release.

Configuration
REQ-025 With macro SCROLL_SCHED_PREEMPT_EN defined, i_req[0] high during HOLD when owner != 0 SHALL end HOLD on the next edge, and source 0 SHALL win the following arbitration regardless of the round-robin pointer.
REQ-026 Without SCROLL_SCHED_PREEMPT_EN, HOLD SHALL never be cut short and source 0 SHALL have no priority.

Structure
REQ-027 A shared package scroll_sched_pkg SHALL hold the FSM state enum, the DATA_W and HOLD_CYCLES derivation functions, and the owner-width function.
REQ-028 Round-robin selection SHALL be a separate sub-module rr_arbiter (inputs: request vector, last owner; outputs: grant valid, grant index), purely combinational; all sequential logic remains in scroll_scheduler.

Verification (FREQ=1000, HOLD_MS=4, so HOLD_CYCLES=4; REQUESTERS=3, DIGITS=4)
REQ-029 Reset release, i_req=001, data0=0x1234 -> o_ack=001 at cycle 2, o_shift at cycle 3, o_full=0x1234, o_busy low at cycle 8.
REQ-030 i_req=111 held and re-asserted after each ack -> owners in order 0,1,2,0, each shown for 4 HOLD cycles.
REQ-031 i_req=010 for one cycle only while HOLD runs for source 0 -> source 1 never acked; display keeps source-0 data.
REQ-032 i_rst_n pulsed low during HOLD for source 2 -> outputs cleared at once, no o_ack or o_shift until a new request arrives.
REQ-033 SCROLL_SCHED_PREEMPT_EN defined, source 2 in HOLD cycle 1, i_req=101 -> HOLD ends, o_ack=001 two cycles later; macro undefined -> HOLD completes all 4 cycles before source 0 is acked.
